// File: rtl/rsa_rfid_pkg.sv
// Shared types and constants for the RSA receive framer.
// State encoding, drop causes and the default frame start marker.
package rsa_rfid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    HOLD
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_EVENMOD = 2'b11;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/rsa_frame_rx_if.sv
// FIFO-side and controller-side signals of the RSA receive framer.
// master = framer, slave = FIFO plus controller.
interface rsa_frame_rx_if #(
  parameter int WordSize = 32
);
  logic [7:0]          r_data;
  logic                rx_empty;
  logic                rd_uart;
  logic [WordSize-1:0] msg_word;
  logic [WordSize-1:0] exp_word;
  logic [WordSize-1:0] mod_word;
  logic                frame_valid;
  logic                frame_ready;
  logic                frame_err;
  logic [1:0]          err_code;

  modport master (
    input  r_data, rx_empty, frame_ready,
    output rd_uart, msg_word, exp_word,
    output mod_word, frame_valid,
    output frame_err, err_code
  );

  modport slave (
    output r_data, rx_empty, frame_ready,
    input  rd_uart, msg_word, exp_word,
    input  mod_word, frame_valid,
    input  frame_err, err_code
  );
endinterface

// File: rtl/rsa_frame_timeout.sv
// Inter-byte gap counter: cleared on every pop, counts while enabled.
// expired flags the cycle whose closing edge would reach TIMEOUT.
module rsa_frame_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && !clr
                && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/rsa_frame_rx.sv
// Receive framer: sync hunt, payload assembly, checksum/modulus check,
// and valid/ready hand-off of msg/exp/mod words to the controller.
module rsa_frame_rx
  import rsa_rfid_pkg::*;
#(
  parameter int         WordSize  = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         TIMEOUT   = 100000
) (
  input  logic          clk,
  input  logic          reset,
  rsa_frame_rx_if.master bus
);
  localparam int NB = WordSize / 8;
  localparam int NP = 3 * NB;
  localparam int CW = $clog2(NP);
  localparam int SW = 3 * WordSize;

  state_t state, state_nxt;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    xacc, xacc_nxt;
  logic [SW-1:0] sreg, sreg_nxt;

  logic pop, load, err_set;
  logic active, expired;
  logic [1:0] err_nxt;

  logic [WordSize-1:0] msg_q, exp_q, mod_q;
  logic                err_q;
  logic [1:0]          code_q;

  assign active = (state == PAYLOAD)
               || (state == CHECK);

  rsa_frame_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (pop || !active),
    .en     (active),
    .expired(expired)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    xacc_nxt  = xacc;
    sreg_nxt  = sreg;
    pop       = 1'b0;
    load      = 1'b0;
    err_set   = 1'b0;
    err_nxt   = ERR_NONE;
    unique case (state)
      IDLE: begin
        pop = !bus.rx_empty;
        if (pop && bus.r_data == SYNC_BYTE) begin
          state_nxt = PAYLOAD;
          cnt_nxt   = '0;
          xacc_nxt  = '0;
        end
      end
      PAYLOAD: begin
        pop = !bus.rx_empty;
        if (pop) begin
          sreg_nxt = {sreg[SW-9:0], bus.r_data};
          xacc_nxt = xacc ^ bus.r_data;
          cnt_nxt  = cnt + CW'(1);
          if (cnt == CW'(NP - 1)) begin
            state_nxt = CHECK;
          end
        end else if (expired) begin
          err_set   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        pop = !bus.rx_empty;
        if (pop) begin
          state_nxt = IDLE;
          if (bus.r_data != xacc) begin
            err_set = 1'b1;
            err_nxt = ERR_CSUM;
          end else if (!sreg[0]) begin
            err_set = 1'b1;
            err_nxt = ERR_EVENMOD;
          end else begin
            load      = 1'b1;
            state_nxt = HOLD;
          end
        end else if (expired) begin
          err_set   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (bus.frame_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      xacc   <= '0;
      sreg   <= '0;
      msg_q  <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      xacc  <= xacc_nxt;
      sreg  <= sreg_nxt;
      err_q <= err_set;
      if (err_set) begin
        code_q <= err_nxt;
      end
      if (load) begin
        msg_q <= sreg[SW-1 -: WordSize];
        exp_q <= sreg[2*WordSize-1 -: WordSize];
        mod_q <= sreg[WordSize-1:0];
      end
    end
  end

  // Async reset must also silence the combinational pop strobe.
  assign bus.rd_uart     = pop && !reset;
  assign bus.msg_word    = msg_q;
  assign bus.exp_word    = exp_q;
  assign bus.mod_word    = mod_q;
  assign bus.frame_valid = (state == HOLD);
  assign bus.frame_err   = err_q;
  assign bus.err_code    = code_q;

endmodule

// File: tb/tb_rsa_frame_rx.sv
// Scoreboard bench for rsa_frame_rx: FIFO model, expected-frame and
// expected-error queues, monitor comparing on every accept or drop.
module tb_rsa_frame_rx;
  import rsa_rfid_pkg::*;

  localparam int W  = 32;
  localparam int TO = 20;

  typedef struct {
    logic [31:0] m;
    logic [31:0] e;
    logic [31:0] d;
  } frame_t;

  localparam logic [7:0] GOOD[14] = '{
    8'hA5, 8'h00, 8'h00, 8'h00, 8'h41,
    8'h00, 8'h00, 8'h00, 8'h11,
    8'h00, 8'h00, 8'h0C, 8'hA1, 8'hFD
  };
  localparam logic [7:0] BADCS[14] = '{
    8'hA5, 8'h00, 8'h00, 8'h00, 8'h41,
    8'h00, 8'h00, 8'h00, 8'h11,
    8'h00, 8'h00, 8'h0C, 8'hA1, 8'hFE
  };
  localparam logic [7:0] EVEN[14] = '{
    8'hA5, 8'h00, 8'h00, 8'h00, 8'h41,
    8'h00, 8'h00, 8'h00, 8'h11,
    8'h00, 8'h00, 8'h0C, 8'hA0, 8'hFC
  };
  localparam logic [7:0] GOOD2[14] = '{
    8'hA5, 8'h12, 8'h34, 8'h56, 8'h78,
    8'h00, 8'h01, 8'h00, 8'h01,
    8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A
  };

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rsa_frame_rx_if #(.WordSize(W)) bus();

  rsa_frame_rx #(
    .WordSize (W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] fifo[$];
  frame_t     exp_frames[$];
  logic [1:0] exp_errs[$];
  int tests = 0;
  int fails = 0;
  int gap   = 0;
  frame_t     mon_f;
  logic [1:0] mon_c;

  // FIFO model: pop decided mid-cycle, head updated just after the edge
  initial begin
    logic do_pop;
    bus.rx_empty = 1'b1;
    bus.r_data   = 8'h00;
    forever begin
      @(negedge clk);
      do_pop = bus.rd_uart;
      @(posedge clk);
      #1;
      if (do_pop && fifo.size() != 0) void'(fifo.pop_front());
      bus.rx_empty = (fifo.size() == 0);
      bus.r_data   = (fifo.size() == 0) ? 8'h00 : fifo[0];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_valid && bus.frame_ready) begin
        tests++;
        if (exp_frames.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame got msg=%h exp=%h mod=%h",
                   bus.msg_word, bus.exp_word, bus.mod_word);
        end else begin
          mon_f = exp_frames.pop_front();
          if ({bus.msg_word, bus.exp_word, bus.mod_word}
              !== {mon_f.m, mon_f.e, mon_f.d}) begin
            fails++;
            $display("FAIL frame_words got %h/%h/%h want %h/%h/%h",
                     bus.msg_word, bus.exp_word, bus.mod_word,
                     mon_f.m, mon_f.e, mon_f.d);
          end
        end
      end
      if (bus.frame_err) begin
        tests++;
        if (exp_errs.size() == 0) begin
          fails++;
          $display("FAIL unexpected_err got code=%b", bus.err_code);
        end else begin
          mon_c = exp_errs.pop_front();
          if (bus.err_code !== mon_c) begin
            fails++;
            $display("FAIL err_code got %b want %b",
                     bus.err_code, mon_c);
          end
          if (mon_c == ERR_TIMEOUT) begin
            tests++;
            if (gap != TO) begin
              fails++;
              $display("FAIL timeout_gap got %0d idle want %0d",
                       gap, TO);
            end
          end
        end
      end
      gap = bus.rd_uart ? 0 : gap + 1;
    end
  end

  task automatic check(input string name,
                       input logic [95:0] got,
                       input logic [95:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic push_frame(input logic [7:0] b[14], input int n);
    for (int i = 0; i < n; i++) fifo.push_back(b[i]);
  endtask

  task automatic exp_frame(input logic [31:0] m,
                           input logic [31:0] e,
                           input logic [31:0] d);
    frame_t f;
    f.m = m; f.e = e; f.d = d;
    exp_frames.push_back(f);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((fifo.size() != 0 || exp_frames.size() != 0
            || exp_errs.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_wait got %0d cycles want <%0d",
               name, n, budget);
    end
  endtask

  initial begin
    int bad_v, bad_r, bad_w, n;
    reset = 1'b1;
    bus.frame_ready = 1'b1;
    fifo.push_back(8'h3C);
    repeat (3) @(negedge clk);
    check("rst_msg",   96'(bus.msg_word), 96'h0);
    check("rst_exp",   96'(bus.exp_word), 96'h0);
    check("rst_mod",   96'(bus.mod_word), 96'h0);
    check("rst_flags", 96'({bus.frame_valid, bus.frame_err,
                            bus.err_code, bus.rd_uart}), 96'h0);
    reset = 1'b0;

    // good frame, back-to-back
    push_frame(GOOD, 14);
    exp_frame(32'h41, 32'h11, 32'hCA1);
    wait_idle("good", 100);
    check("good_code", 96'(bus.err_code), 96'(ERR_NONE));

    // garbage before sync
    fifo.push_back(8'h3C);
    fifo.push_back(8'hFF);
    push_frame(GOOD, 14);
    exp_frame(32'h41, 32'h11, 32'hCA1);
    wait_idle("garbage", 100);

    // bad checksum
    push_frame(BADCS, 14);
    exp_errs.push_back(ERR_CSUM);
    wait_idle("csum", 100);
    check("csum_code", 96'(bus.err_code), 96'(ERR_CSUM));
    check("csum_words", {bus.msg_word, bus.exp_word, bus.mod_word},
          {32'h41, 32'h11, 32'hCA1});
    check("csum_valid", 96'(bus.frame_valid), 96'h0);

    // even modulus
    push_frame(EVEN, 14);
    exp_errs.push_back(ERR_EVENMOD);
    wait_idle("even", 100);
    check("even_code", 96'(bus.err_code), 96'(ERR_EVENMOD));
    check("even_words", {bus.msg_word, bus.exp_word, bus.mod_word},
          {32'h41, 32'h11, 32'hCA1});

    // timeout after 5th payload byte, then a fresh good frame
    push_frame(GOOD2, 6);
    exp_errs.push_back(ERR_TIMEOUT);
    wait_idle("timeout", 100);
    check("to_code", 96'(bus.err_code), 96'(ERR_TIMEOUT));
    push_frame(GOOD2, 14);
    exp_frame(32'h12345678, 32'h00010001, 32'hDEADBEEF);
    wait_idle("after_to", 100);

    // backpressure with more bytes queued
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
    push_frame(GOOD, 14);
    fifo.push_back(8'hA5);
    fifo.push_back(8'h00);
    fifo.push_back(8'h00);
    exp_frame(32'h41, 32'h11, 32'hCA1);
    n = 0;
    while (!bus.frame_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach", 96'(n < 100), 96'h1);
    bad_v = 0; bad_r = 0; bad_w = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.frame_valid !== 1'b1) bad_v++;
      if (bus.rd_uart !== 1'b0) bad_r++;
      if ({bus.msg_word, bus.exp_word, bus.mod_word}
          !== {32'h41, 32'h11, 32'hCA1}) bad_w++;
    end
    check("bp_valid", 96'(bad_v), 96'h0);
    check("bp_nopop", 96'(bad_r), 96'h0);
    check("bp_words", 96'(bad_w), 96'h0);
    check("bp_fifo",  96'(fifo.size()), 96'd3);
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    n = 0;
    while (fifo.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_drain", 96'(n < 50), 96'h1);

    // reset mid-frame
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_words",
          {bus.msg_word, bus.exp_word, bus.mod_word}, 96'h0);
    check("mid_rst_flags", 96'({bus.frame_valid, bus.frame_err,
                                bus.err_code, bus.rd_uart}), 96'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("queues_empty",
          96'(exp_frames.size() + exp_errs.size()), 96'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
